pipe_addsub: RTL and testbench

- Parametrised, pipelined adder/subtractor with valid/ready handshakes on input and output.
- Operand width is split into segments of SEG bits. Each pipeline stage resolves one segment and passes its carry to the next stage.
- Sustains one operation per cycle at WIDTH values where a single-cycle ripple adder would miss timing.
- Sits between operand producers and accumulator/ALU datapaths. Supersedes the fixed 4-bit combinational adder.

---
 rtl/pipe_addsub.sv | 151 +++++++++++++++
 tb/tb_pipe_addsub.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - pipelined segmented adder/subtractor with valid/ready handshakes
//
// Purpose: computes {cout,s} = a + b + cin (sub=0) or a + ~b + ~cin (sub=1),
// resolving SEG bits per pipeline slot. STAGES = WIDTH/SEG is both the latency
// and the number of operations held. Slots compact forward under backpressure.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   a, b       operands (WIDTH)
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0 = add, 1 = subtract
//   in_valid   operands valid
//   in_ready   slot 0 can accept
//   s          registered result (WIDTH)
//   cout       carry-out of MSB (sub: 1 = no borrow)
//   ovf        two's-complement overflow
//   out_valid  result valid
//   out_ready  consumer accepts result
module pipe_addsub #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam int STAGES = WIDTH / SEG;

   logic [STAGES-1:0] valid;
   logic [STAGES-1:0] adv;
   logic [WIDTH-1:0]  b_x;
   logic              c_x;
   logic              accept;

   // Subtraction is folded into the operands once, at accept time.
   assign b_x = sub ? ~b : b;
   assign c_x = sub ? ~cin : cin;

   // A slot advances unless every slot downstream of it is full and the
   // consumer is stalling. Written as a flat reduction over the valid bits so
   // there is no combinational chain through adv itself.
   always_comb begin
      logic full_above;
      full_above = 1'b1;
      adv        = '0;
      for (int k = 0; k < STAGES; k++) begin
         full_above = 1'b1;
         for (int j = k + 1; j < STAGES; j++) begin
            full_above = full_above & valid[j];
         end
         adv[k] = valid[k] & (out_ready | ~full_above);
      end
   end

   assign in_ready = ~valid[0] | adv[0];
   assign accept   = in_valid & in_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_slot
      // Width of the operand bits still unresolved when entering stage k.
      localparam int OPW = WIDTH - k * SEG;

      logic [OPW-1:0]       op_a;
      logic [OPW-1:0]       op_b;
      logic                 op_c;
      logic                 take;
      logic [SEG:0]         sum;
      logic                 v_r;
      logic                 c_r;
      logic [(k+1)*SEG-1:0] s_r;

      if (k == 0) begin : g_src
         assign op_a = a;
         assign op_b = b_x;
         assign op_c = c_x;
         assign take = accept;
      end else begin : g_src
         assign op_a = g_slot[k-1].g_pend.a_r;
         assign op_b = g_slot[k-1].g_pend.b_r;
         assign op_c = g_slot[k-1].c_r;
         assign take = adv[k-1];
      end

      assign sum      = {1'b0, op_a[SEG-1:0]} + {1'b0, op_b[SEG-1:0]} + {{SEG{1'b0}}, op_c};
      assign valid[k] = v_r;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_r <= 1'b0;
            c_r <= 1'b0;
         end else if (take) begin
            v_r <= 1'b1;
            c_r <= sum[SEG];
         end else if (adv[k]) begin
            v_r <= 1'b0;
         end
      end

      // Resolved low segments accumulate: this stage's segment goes on top.
      if (k == 0) begin : g_res
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)    s_r <= '0;
            else if (take) s_r <= sum[SEG-1:0];
         end
      end else begin : g_res
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)    s_r <= '0;
            else if (take) s_r <= {sum[SEG-1:0], g_slot[k-1].s_r};
         end
      end

      // Only the still-pending upper operand segments travel forward.
      if (k < STAGES - 1) begin : g_pend
         logic [OPW-SEG-1:0] a_r;
         logic [OPW-SEG-1:0] b_r;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_r <= '0;
               b_r <= '0;
            end else if (take) begin
               a_r <= op_a[OPW-1:SEG];
               b_r <= op_b[OPW-1:SEG];
            end
         end
      end

      // Carry into the MSB is a^b^sum at that bit; xor with carry-out gives overflow.
      if (k == STAGES - 1) begin : g_last
         logic ovf_r;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)    ovf_r <= 1'b0;
            else if (take) ovf_r <= op_a[SEG-1] ^ op_b[SEG-1] ^ sum[SEG-1] ^ sum[SEG];
         end
      end
   end

   assign s         = g_slot[STAGES-1].s_r;
   assign cout      = g_slot[STAGES-1].c_r;
   assign ovf       = g_slot[STAGES-1].g_last.ovf_r;
   assign out_valid = valid[STAGES-1];
endmodule

// File: tb/tb_pipe_addsub.sv
// tb/tb_pipe_addsub.sv - scoreboard bench for pipe_addsub (WIDTH=16, SEG=4)
module tb_pipe_addsub;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        sub = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] s;
   logic        cout;
   logic        ovf;
   logic        out_valid;
   logic        out_ready = 1'b1;

   int total = 0;
   int bad = 0;

   // expected entry: {s[15:0], cout, ovf}
   logic [17:0] exp_q[$];

   always #5 clk = ~clk;

   pipe_addsub #(.WIDTH(16), .SEG(4)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .sub(sub),
      .in_valid(in_valid), .in_ready(in_ready), .s(s), .cout(cout), .ovf(ovf),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                         input logic cv, input logic sv);
      logic [15:0] bx;
      logic        cx;
      logic [16:0] r;
      logic        o;
      bx = sv ? ~bv : bv;
      cx = sv ? ~cv : cv;
      r  = {1'b0, av} + {1'b0, bx} + {16'd0, cx};
      o  = (av[15] == bx[15]) && (r[15] != av[15]);
      return {r[15:0], r[16], o};
   endfunction

   // Monitor: pops one expectation per output transfer.
   always @(negedge clk) begin
      logic [17:0] e;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out_valid", 32'(out_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("s", 32'(s), 32'(e[17:2]));
            chk("cout", 32'(cout), 32'(e[1]));
            chk("ovf", 32'(ovf), 32'(e[0]));
         end
      end
   end

   task automatic idle_inputs();
      in_valid = 1'b0;
      a = 'x;
      b = 'x;
   endtask

   task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                       input logic sv, input logic [17:0] e);
      bit acc;
      acc = 1'b0;
      a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
      for (int t = 0; t < 200 && !acc; t++) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) exp_q.push_back(e);
         @(posedge clk); #1;
      end
      chk("send_accept", 32'(acc), 32'd1);
      idle_inputs();
   endtask

   task automatic drain();
      for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
      #1;
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   logic [15:0] bp_a[8] = '{16'h0001, 16'h1111, 16'hF000, 16'h4000, 16'h0003, 16'h0000, 16'hABCD, 16'h7FFF};
   logic [15:0] bp_b[8] = '{16'h0001, 16'h2222, 16'h1000, 16'h4000, 16'h0001, 16'h0001, 16'h1234, 16'hFFFF};
   logic        bp_c[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
   logic        bp_s[8] = '{0, 0, 0, 0, 1, 1, 0, 1};
   logic [17:0] bp_e[8] = '{{16'h0002, 2'b00}, {16'h3333, 2'b00}, {16'h0000, 2'b10}, {16'h8000, 2'b01},
                            {16'h0002, 2'b10}, {16'hFFFF, 2'b00}, {16'hBE02, 2'b00}, {16'h8000, 2'b01}};

   initial begin
      #4_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      bit found;
      int n;
      int cycles;
      idle_inputs();
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      #20 rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: latency and single-cycle pulse
      send(16'h00FF, 16'h0001, 1'b0, 1'b0, {16'h0100, 2'b00});
      for (int e = 1; e <= 5; e++) begin
         @(negedge clk);
         chk($sformatf("latency_edge%0d", e), 32'(out_valid), 32'(e == 4));
         @(posedge clk); #1;
      end
      drain();

      // 2: carry out and signed overflow, back to back
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 2'b10});
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 2'b01});
      found = 1'b0;
      for (int t = 0; t < 10 && !found; t++) begin
         @(negedge clk);
         found = out_valid;
      end
      chk("back2back_first", 32'(found), 32'd1);
      @(negedge clk);
      chk("back2back_second", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      drain();

      // 3: subtraction with borrow-in
      send(16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 2'b00});
      send(16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 2'b11});
      send(16'h0010, 16'h0001, 1'b1, 1'b1, {16'h000E, 2'b10});
      drain();

      // 4: backpressure fills exactly 4 slots, then drains without gaps
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(bp_a[i], bp_b[i], bp_c[i], bp_s[i], bp_e[i]);
      a = bp_a[4]; b = bp_b[4]; cin = bp_c[4]; sub = bp_s[4]; in_valid = 1'b1;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_s_hold", 32'(s), 32'h0002);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("drain_valid%0d", i), 32'(out_valid), 32'd1);
         if (i < 4) begin
            chk($sformatf("refill_ready%0d", i), 32'(in_ready), 32'd1);
            if (in_ready) exp_q.push_back(bp_e[4+i]);
         end
         @(posedge clk); #1;
         if (i < 3) begin
            a = bp_a[5+i]; b = bp_b[5+i]; cin = bp_c[5+i]; sub = bp_s[5+i];
         end else begin
            idle_inputs();
         end
      end
      drain();

      // 5: asynchronous reset with operations in flight
      out_ready = 1'b0;
      send(16'h0001, 16'h0001, 1'b0, 1'b0, {16'h0002, 2'b00});
      send(16'h0002, 16'h0002, 1'b0, 1'b0, {16'h0004, 2'b00});
      send(16'h0003, 16'h0003, 1'b0, 1'b0, {16'h0006, 2'b00});
      @(posedge clk); #1;
      chk("pre_reset_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_s", 32'(s), 32'd0);
      chk("async_rst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      #5 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         chk("no_stale", 32'(out_valid), 32'd0);
      end
      @(posedge clk); #1;
      send(16'h1234, 16'h4321, 1'b0, 1'b0, {16'h5555, 2'b00});
      drain();

      // 6: random traffic against the reference model
      n = 0;
      cycles = 0;
      while (n < 10000 && cycles < 60000) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) != 0) begin
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
         end else begin
            idle_inputs();
         end
         @(negedge clk);
         if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, cin, sub));
            n++;
         end
         @(posedge clk); #1;
         cycles++;
      end
      chk("random_ops_issued", 32'(n), 32'd10000);
      idle_inputs();
      out_ready = 1'b1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
